// File: rtl/alu_arbiter_if.sv
// Signal bundle between the two requesters, the shared ALU and the alu_arbiter.
// Handshake rule for every valid/ready pair below: a transfer happens on a rising
// clock edge where valid && ready are both high; valid never waits on ready, and the
// payload (op/a/b or rsp_data) stays stable while valid is high and ready is low.
interface alu_arbiter_if #(
    parameter int DATA_W = 8
);
    logic              req0_valid;
    logic              req0_ready;
    logic [1:0]        req0_op;
    logic [DATA_W-1:0] req0_a;
    logic [DATA_W-1:0] req0_b;

    logic              req1_valid;
    logic              req1_ready;
    logic [1:0]        req1_op;
    logic [DATA_W-1:0] req1_a;
    logic [DATA_W-1:0] req1_b;

    logic              rsp0_valid;
    logic              rsp0_ready;
    logic              rsp1_valid;
    logic              rsp1_ready;
    logic [DATA_W-1:0] rsp_data;

    logic [1:0]        alu_opcode;
    logic [DATA_W-1:0] alu_a;
    logic [DATA_W-1:0] alu_b;
    logic [DATA_W-1:0] alu_out;

    logic [7:0]        ops_done;

    // Arbiter side
    modport slave (
        input  req0_valid, req0_op, req0_a, req0_b,
        input  req1_valid, req1_op, req1_a, req1_b,
        input  rsp0_ready, rsp1_ready, alu_out,
        output req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_data,
        output alu_opcode, alu_a, alu_b, ops_done
    );

    // Requester / ALU side
    modport master (
        output req0_valid, req0_op, req0_a, req0_b,
        output req1_valid, req1_op, req1_a, req1_b,
        output rsp0_ready, rsp1_ready, alu_out,
        input  req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_data,
        input  alu_opcode, alu_a, alu_b, ops_done
    );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin arbiter that time-shares one combinational ALU between two requesters,
// one operation in flight at a time (IDLE -> EXEC -> RESP).
module alu_arbiter #(
    parameter int DATA_W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    alu_arbiter_if.slave bus,
    output logic [1:0]   dbg_state
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic              last_grant_q, last_grant_d;
    logic              owner_q, owner_d;
    logic [1:0]        alu_opcode_q, alu_opcode_d;
    logic [DATA_W-1:0] alu_a_q, alu_a_d;
    logic [DATA_W-1:0] alu_b_q, alu_b_d;
    logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
    logic [7:0]        ops_done_q, ops_done_d;

    logic any_req;
    logic winner;
    logic req_hs;
    logic owner_rsp_ready;
    logic rsp_hs;

    // On a tie the requester that was not served last wins.
    always_comb begin
        any_req = bus.req0_valid | bus.req1_valid;
        if (bus.req0_valid && bus.req1_valid) begin
            winner = ~last_grant_q;
        end else begin
            winner = bus.req1_valid;
        end
        req_hs          = (state_q == IDLE) && any_req;
        owner_rsp_ready = owner_q ? bus.rsp1_ready : bus.rsp0_ready;
        rsp_hs          = (state_q == RESP) && owner_rsp_ready;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (any_req) state_d = EXEC;
            EXEC:    state_d = RESP;
            RESP:    if (owner_rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.req0_ready = req_hs && !winner;
        bus.req1_ready = req_hs && winner;
        bus.rsp0_valid = (state_q == RESP) && !owner_q;
        bus.rsp1_valid = (state_q == RESP) && owner_q;
        bus.rsp_data   = rsp_data_q;
        bus.alu_opcode = alu_opcode_q;
        bus.alu_a      = alu_a_q;
        bus.alu_b      = alu_b_q;
        bus.ops_done   = ops_done_q;
        dbg_state      = state_q;
    end

    // ALU operand registers keep their last value after an operation completes.
    always_comb begin
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        alu_opcode_d = alu_opcode_q;
        alu_a_d      = alu_a_q;
        alu_b_d      = alu_b_q;
        rsp_data_d   = rsp_data_q;
        ops_done_d   = ops_done_q;
        if (req_hs) begin
            owner_d      = winner;
            alu_opcode_d = winner ? bus.req1_op : bus.req0_op;
            alu_a_d      = winner ? bus.req1_a  : bus.req0_a;
            alu_b_d      = winner ? bus.req1_b  : bus.req0_b;
        end
        if (state_q == EXEC) begin
            rsp_data_d = bus.alu_out;
        end
        if (rsp_hs) begin
            last_grant_d = owner_q;
            ops_done_d   = ops_done_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner_q      <= 1'b0;
            last_grant_q <= 1'b1;
            alu_opcode_q <= 2'b00;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            rsp_data_q   <= '0;
            ops_done_q   <= 8'd0;
        end else begin
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            alu_opcode_q <= alu_opcode_d;
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
            rsp_data_q   <= rsp_data_d;
            ops_done_q   <= ops_done_d;
        end
    end
endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: a behavioural ALU drives alu_out, and each
// expectation is either a hand-computed constant or taken from that ALU model.
module tb_alu_arbiter;
    logic       clk;
    logic       rst_n;
    logic [1:0] dbg_state;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [7:0] exp_q[$];
    logic       grant_q[$];

    alu_arbiter_if #(.DATA_W(8)) bus ();

    alu_arbiter #(.DATA_W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    function automatic logic [7:0] alu_f(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
        case (op)
            2'b00:   return a + b;
            2'b01:   return a ^ b;
            default: return ~(a & b);
        endcase
    endfunction

    assign bus.alu_out = alu_f(bus.alu_opcode, bus.alu_a, bus.alu_b);

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout, expected bench completion");
        $fatal(1, "watchdog expired");
    end

    task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic idle_inputs();
        bus.req0_valid = 1'b0; bus.req0_op = 2'b00; bus.req0_a = 8'h00; bus.req0_b = 8'h00;
        bus.req1_valid = 1'b0; bus.req1_op = 2'b00; bus.req1_a = 8'h00; bus.req1_b = 8'h00;
        bus.rsp0_ready = 1'b0; bus.rsp1_ready = 1'b0;
    endtask

    task automatic apply_reset();
        idle_inputs();
        rst_n = 1'b0;
        cyc();
        cyc();
        rst_n = 1'b1;
        cyc();
    endtask

    task automatic drive_req(input int rq, input logic v, input logic [1:0] op,
                             input logic [7:0] a, input logic [7:0] b);
        if (rq == 0) begin
            bus.req0_valid = v; bus.req0_op = op; bus.req0_a = a; bus.req0_b = b;
        end else begin
            bus.req1_valid = v; bus.req1_op = op; bus.req1_a = a; bus.req1_b = b;
        end
    endtask

    task automatic check_reset_values(input string tag);
        chk8({tag, "_state"},      {6'd0, dbg_state}, 8'h00);
        chk1({tag, "_rsp0_valid"}, bus.rsp0_valid, 1'b0);
        chk1({tag, "_rsp1_valid"}, bus.rsp1_valid, 1'b0);
        chk8({tag, "_rsp_data"},   bus.rsp_data, 8'h00);
        chk8({tag, "_alu_opcode"}, {6'd0, bus.alu_opcode}, 8'h00);
        chk8({tag, "_alu_a"},      bus.alu_a, 8'h00);
        chk8({tag, "_alu_b"},      bus.alu_b, 8'h00);
        chk8({tag, "_ops_done"},   bus.ops_done, 8'h00);
        chk1({tag, "_req0_ready"}, bus.req0_ready, 1'b0);
        chk1({tag, "_req1_ready"}, bus.req1_ready, 1'b0);
    endtask

    // One uncontended operation with the response accepted immediately.
    task automatic run_op(input int rq, input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] exp_res, input logic [7:0] exp_ops, input string tag);
        drive_req(rq, 1'b1, op, a, b);
        bus.rsp0_ready = 1'b1;
        bus.rsp1_ready = 1'b1;
        settle();
        chk1({tag, "_req0_ready"}, bus.req0_ready, rq == 0);
        chk1({tag, "_req1_ready"}, bus.req1_ready, rq == 1);
        cyc();
        drive_req(rq, 1'b0, op, a, b);
        settle();
        chk8({tag, "_alu_opcode"}, {6'd0, bus.alu_opcode}, {6'd0, op});
        chk8({tag, "_alu_a"}, bus.alu_a, a);
        chk8({tag, "_alu_b"}, bus.alu_b, b);
        chk1({tag, "_rsp_early"}, bus.rsp0_valid | bus.rsp1_valid, 1'b0);
        cyc();
        settle();
        chk1({tag, "_rsp0_valid"}, bus.rsp0_valid, rq == 0);
        chk1({tag, "_rsp1_valid"}, bus.rsp1_valid, rq == 1);
        chk8({tag, "_rsp_data"}, bus.rsp_data, exp_res);
        cyc();
        settle();
        chk1({tag, "_rsp_clear"}, bus.rsp0_valid | bus.rsp1_valid, 1'b0);
        chk8({tag, "_ops_done"}, bus.ops_done, exp_ops);
        chk8({tag, "_idle"}, {6'd0, dbg_state}, 8'h00);
    endtask

    logic [1:0] f_op0 [3] = '{2'b00, 2'b01, 2'b10};
    logic [7:0] f_a0  [3] = '{8'h80, 8'h3C, 8'hF0};
    logic [7:0] f_b0  [3] = '{8'h80, 8'hC3, 8'h33};
    logic [1:0] f_op1 [3] = '{2'b01, 2'b11, 2'b00};
    logic [7:0] f_a1  [3] = '{8'h5A, 8'h0F, 8'hFF};
    logic [7:0] f_b1  [3] = '{8'hFF, 8'hF0, 8'h02};

    initial begin
        int   idx0, idx1, grants, resps;
        logic took0, took1;

        // reset state
        idle_inputs();
        rst_n = 1'b0;
        cyc();
        cyc();
        check_reset_values("reset");
        rst_n = 1'b1;
        cyc();
        settle();
        check_reset_values("post_reset");

        // single add with carry dropped, then xor and nand (opcode 11) on requester 1
        run_op(0, 2'b00, 8'hF0, 8'h20, 8'h10, 8'd1, "add");
        run_op(1, 2'b01, 8'hAA, 8'h0F, 8'hA5, 8'd2, "xor");
        run_op(1, 2'b11, 8'hFF, 8'h0F, 8'hF0, 8'd3, "nand");

        // fairness: both requesters continuously valid for six operations
        apply_reset();
        idx0 = 0; idx1 = 0; grants = 0; resps = 0;
        exp_q.delete();
        grant_q.delete();
        drive_req(0, 1'b1, f_op0[0], f_a0[0], f_b0[0]);
        drive_req(1, 1'b1, f_op1[0], f_a1[0], f_b1[0]);
        bus.rsp0_ready = 1'b1;
        bus.rsp1_ready = 1'b1;
        for (int c = 0; c < 60 && resps < 6; c++) begin
            settle();
            took0 = bus.req0_ready;
            took1 = bus.req1_ready;
            if (took0 || took1) begin
                chk1("fair_grant", took1, 1'(grants % 2));
                grants++;
                grant_q.push_back(took1);
                exp_q.push_back(took1 ? alu_f(bus.req1_op, bus.req1_a, bus.req1_b)
                                      : alu_f(bus.req0_op, bus.req0_a, bus.req0_b));
            end
            if (bus.rsp0_valid || bus.rsp1_valid) begin
                chk1("fair_rsp_pending", exp_q.size() != 0, 1'b1);
                chk1("fair_one_rsp", bus.rsp0_valid & bus.rsp1_valid, 1'b0);
                if (exp_q.size() != 0) begin
                    chk1("fair_owner", bus.rsp1_valid, grant_q.pop_front());
                    chk8("fair_data", bus.rsp_data, exp_q.pop_front());
                end
                resps++;
            end
            cyc();
            if (took0) begin
                idx0++;
                if (idx0 < 3) drive_req(0, 1'b1, f_op0[idx0], f_a0[idx0], f_b0[idx0]);
                else bus.req0_valid = 1'b0;
            end
            if (took1) begin
                idx1++;
                if (idx1 < 3) drive_req(1, 1'b1, f_op1[idx1], f_a1[idx1], f_b1[idx1]);
                else bus.req1_valid = 1'b0;
            end
        end
        chk8("fair_resp_count", 8'(resps), 8'd6);
        chk8("fair_ops_done", bus.ops_done, 8'd6);

        // backpressure on requester 0 while requester 1 waits
        drive_req(0, 1'b1, 2'b00, 8'h01, 8'h02);
        drive_req(1, 1'b1, 2'b01, 8'hFF, 8'h00);
        bus.rsp0_ready = 1'b0;
        bus.rsp1_ready = 1'b1;
        settle();
        chk1("bp_req0_ready", bus.req0_ready, 1'b1);
        chk1("bp_req1_ready", bus.req1_ready, 1'b0);
        cyc();
        bus.req0_valid = 1'b0;
        settle();
        chk1("bp_exec_req1_ready", bus.req1_ready, 1'b0);
        cyc();
        settle();
        chk1("bp_rsp0_valid", bus.rsp0_valid, 1'b1);
        chk8("bp_rsp_data", bus.rsp_data, 8'h03);
        for (int i = 0; i < 5; i++) begin
            cyc();
            settle();
            chk1("bp_hold_valid", bus.rsp0_valid, 1'b1);
            chk8("bp_hold_data", bus.rsp_data, 8'h03);
            chk1("bp_hold_rsp1", bus.rsp1_valid, 1'b0);
            chk1("bp_hold_req1_ready", bus.req1_ready, 1'b0);
        end
        bus.rsp0_ready = 1'b1;
        settle();
        chk1("bp_hs_req1_ready", bus.req1_ready, 1'b0);
        cyc();
        settle();
        chk1("bp_rsp0_cleared", bus.rsp0_valid, 1'b0);
        chk1("bp_req1_granted", bus.req1_ready, 1'b1);
        chk8("bp_ops_done_1", bus.ops_done, 8'd7);
        cyc();
        bus.req1_valid = 1'b0;
        cyc();
        settle();
        chk1("bp_rsp1_valid", bus.rsp1_valid, 1'b1);
        chk8("bp_rsp1_data", bus.rsp_data, 8'hFF);
        cyc();
        settle();
        chk8("bp_ops_done_2", bus.ops_done, 8'd8);

        // reset asserted while an operation is in EXEC
        drive_req(0, 1'b1, 2'b00, 8'h12, 8'h34);
        bus.rsp0_ready = 1'b1;
        settle();
        chk1("rst_mid_req0_ready", bus.req0_ready, 1'b1);
        cyc();
        bus.req0_valid = 1'b0;
        settle();
        chk8("rst_mid_in_exec", {6'd0, dbg_state}, 8'h01);
        chk8("rst_mid_alu_a", bus.alu_a, 8'h12);
        rst_n = 1'b0;
        settle();
        check_reset_values("rst_mid");
        cyc();
        cyc();
        chk1("rst_mid_no_rsp0", bus.rsp0_valid, 1'b0);
        chk1("rst_mid_no_rsp1", bus.rsp1_valid, 1'b0);
        rst_n = 1'b1;
        cyc();
        run_op(0, 2'b01, 8'h0F, 8'hF0, 8'hFF, 8'd1, "after_rst");

        // 255 more completions take ops_done from 1 through 8'hFF to 8'h00
        for (int i = 0; i < 255; i++) begin
            logic [7:0] a, b;
            logic [1:0] op;
            a  = 8'(i);
            b  = 8'hA5 ^ 8'(i);
            op = 2'(i % 3);
            run_op(i % 2, op, a, b, alu_f(op, a, b), 8'(i + 2), "wrap");
        end
        chk8("wrap_ops_done", bus.ops_done, 8'h00);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
